flow_ctl: RTL and testbench

Decode-stage flow-control unit that sits between instruction memory and the program counter. It registers each fetched instruction into a one-entry decode register and decodes jumps, jump-register and conditional branches into PC redirect controls. It detects load-use hazards and requests a PC hold, and it squashes wrong-path instructions after a taken transfer. It is the consumer-side counterpart of the PC: the PC emits fetch addresses, and this block emits everything the PC needs to choose its next value.

---
 rtl/flow_ctl_if.sv | 27 ++
 rtl/flow_ctl.sv | 115 +++++++++++
 tb/tb_flow_ctl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_ctl_if.sv
// Decode-stage flow-control bus between fetch/register-file (master) and flow_ctl (slave).
interface flow_ctl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr;
  logic [31:0]      rsData;
  logic [31:0]      rtData;
  logic [31:0]      cmd;
  logic             isBubble;
  logic             isJmp;
  logic             isJr;
  logic             isBr;
  logic [15:0]      imm;
  logic [25:0]      jmpAddr;
  logic [31:0]      rrs;
  logic [CNT_W-1:0] lostCnt;

  modport master (
    output instr, rsData, rtData,
    input  cmd, isBubble, isJmp, isJr, isBr, imm, jmpAddr, rrs, lostCnt
  );

  modport slave (
    input  instr, rsData, rtData,
    output cmd, isBubble, isJmp, isJr, isBr, imm, jmpAddr, rrs, lostCnt
  );
endinterface

// File: rtl/flow_ctl.sv
// Decode register, PC redirect decode, load-use stall and wrong-path squash.
// Optional FLOW_CTL_DELAY_SLOT_EN: branch-delay-slot semantics, no squash.
//
// state | meaning
// RUN   | normal decode; transfers and load-use hazards are acted on
// FLUSH | squashing wrong-path fetches, sq counts the remaining ones
module flow_ctl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  flow_ctl_if.slave  bus
);

`ifdef FLOW_CTL_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [2:0] SQ_INIT  = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [2:0]       sq;
  logic [31:0]      cmd_q;
  logic [CNT_W-1:0] lost_q;

  logic [5:0] c_op, i_op;
  logic [4:0] ld_rt;
  logic       is_jmp, is_jr, is_br, xfer;
  logic       reads_rs, reads_rt, hazard, bubble;
  logic       squash_load, lost_inc;

  assign c_op  = cmd_q[31:26];
  assign i_op  = bus.instr[31:26];
  assign ld_rt = cmd_q[20:16];

  assign is_jmp = (c_op == OP_J) || (c_op == OP_JAL);
  assign is_jr  = (c_op == OP_RTYPE) && (cmd_q[5:0] == FN_JR);
  assign is_br  = ((c_op == OP_BEQ) && (bus.rsData == bus.rtData)) ||
                  ((c_op == OP_BNE) && (bus.rsData != bus.rtData));
  assign xfer   = is_jmp | is_jr | is_br;

  assign reads_rs = (i_op != OP_J) && (i_op != OP_JAL);
  assign reads_rt = (i_op == OP_RTYPE) || (i_op == OP_BEQ) ||
                    (i_op == OP_BNE)   || (i_op == OP_SW);

  always_comb begin
    hazard = 1'b0;
    if (state == RUN && c_op == OP_LW && ld_rt != 5'd0) begin
      hazard = (reads_rs && bus.instr[25:21] == ld_rt) ||
               (reads_rt && bus.instr[20:16] == ld_rt);
    end
  end

  // Disjoint by opcode today, but a transfer must never also hold the PC.
  assign bubble = hazard & ~xfer;

  assign squash_load = ((state == RUN) && xfer && !DELAY_SLOT) || (state == FLUSH);
  assign lost_inc    = bubble | squash_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      sq     <= 3'd0;
      cmd_q  <= 32'd0;
      lost_q <= '0;
    end else begin
      if (lost_inc && lost_q != '1) lost_q <= lost_q + 1'b1;

      if (state == RUN && xfer) begin
        if (DELAY_SLOT) begin
          cmd_q <= bus.instr;
        end else begin
          cmd_q <= 32'd0;
          if (FLUSH_CYCLES > 1) begin
            state <= FLUSH;
            sq    <= SQ_INIT;
          end
        end
      end else if (bubble) begin
        // PC holds, so the same instr is re-presented next cycle.
        cmd_q <= 32'd0;
      end else if (state == FLUSH) begin
        cmd_q <= 32'd0;
        sq    <= sq - 3'd1;
        if (sq == 3'd1) state <= RUN;
      end else begin
        cmd_q <= bus.instr;
      end
    end
  end

  assign bus.cmd      = cmd_q;
  assign bus.isBubble = bubble;
  assign bus.isJmp    = is_jmp;
  assign bus.isJr     = is_jr;
  assign bus.isBr     = is_br;
  assign bus.imm      = cmd_q[15:0];
  assign bus.jmpAddr  = cmd_q[25:0];
  assign bus.rrs      = bus.rsData;
  assign bus.lostCnt  = lost_q;

endmodule

// File: tb/tb_flow_ctl.sv
// Self-checking bench for flow_ctl: three instances (FLUSH 1/3, CNT_W 16/4) on shared stimulus.
module tb_flow_ctl;

`ifdef FLOW_CTL_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, rs_data, rt_data;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] q_cmd[$];
  logic [15:0] q_lost[$];

  logic [31:0] LW_T0, LW_T1, LW_Z, ADD_T1, ADD_Z, ADD_T2, JMP, JAL, BEQ, BNE, JR, TGT;

  always #5 clk = ~clk;

  flow_ctl_if #(.CNT_W(16)) bus_a ();
  flow_ctl_if #(.CNT_W(16)) bus_b ();
  flow_ctl_if #(.CNT_W(4))  bus_c ();

  assign bus_a.instr = instr;  assign bus_a.rsData = rs_data;  assign bus_a.rtData = rt_data;
  assign bus_b.instr = instr;  assign bus_b.rsData = rs_data;  assign bus_b.rtData = rt_data;
  assign bus_c.instr = instr;  assign bus_c.rsData = rs_data;  assign bus_c.rtData = rt_data;

  flow_ctl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  flow_ctl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  flow_ctl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Scoreboard for dut_a: one entry per edge, popped 1ns after that edge.
  always @(posedge clk) begin
    logic [31:0] ec;
    logic [15:0] el;
    #1;
    if (q_cmd.size() != 0) begin
      ec = q_cmd.pop_front();
      el = q_lost.pop_front();
      tests++;
      if (bus_a.cmd !== ec) begin
        fails++;
        $display("FAIL sb_cmd t=%0t got %h exp %h", $time, bus_a.cmd, ec);
      end
      tests++;
      if (bus_a.lostCnt !== el) begin
        fails++;
        $display("FAIL sb_lost t=%0t got %0d exp %0d", $time, bus_a.lostCnt, el);
      end
    end
  end

  task automatic tick(input logic [31:0] i, input logic [31:0] ecmd, input logic [15:0] elost);
    q_cmd.push_back(ecmd);
    q_lost.push_back(elost);
    instr = i;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    tick(LW_T0, LW_T0, 16'd0);
    tick(ADD_T1, 32'd0, 16'd1);
    tick(ADD_T1, ADD_T1, 16'd1);
    tests++;
    if (bus_a.lostCnt !== 16'd1) begin
      fails++; $display("FAIL pre_reset_lost got %0d exp 1", bus_a.lostCnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus_a.cmd !== 32'd0 || bus_a.lostCnt !== 16'd0) begin
      fails++; $display("FAIL reset_async cmd=%h lost=%0d exp 0/0", bus_a.cmd, bus_a.lostCnt);
    end
    tests++;
    if ({bus_a.isBubble, bus_a.isJmp, bus_a.isJr, bus_a.isBr} !== 4'b0 ||
        bus_a.imm !== 16'd0 || bus_a.jmpAddr !== 26'd0) begin
      fails++; $display("FAIL reset_flags got %b imm=%h ja=%h exp 0",
                        {bus_a.isBubble, bus_a.isJmp, bus_a.isJr, bus_a.isBr}, bus_a.imm, bus_a.jmpAddr);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_jump;
    do_reset();
    tick(JMP, JMP, 16'd0);
    tests++;
    if (bus_a.isJmp !== 1'b1 || bus_a.jmpAddr !== 26'h0000040 || bus_a.isBubble !== 1'b0) begin
      fails++; $display("FAIL j_decode isJmp=%b ja=%h exp 1/0000040", bus_a.isJmp, bus_a.jmpAddr);
    end
    tick(ADD_T1, DS ? ADD_T1 : 32'd0, DS ? 16'd0 : 16'd1);
    tick(JAL, JAL, DS ? 16'd0 : 16'd1);
    tests++;
    if (bus_a.isJmp !== 1'b1 || bus_a.jmpAddr !== 26'h3FFFFFF) begin
      fails++; $display("FAIL jal_decode isJmp=%b ja=%h exp 1/3ffffff", bus_a.isJmp, bus_a.jmpAddr);
    end
    tick(ADD_T1, DS ? ADD_T1 : 32'd0, DS ? 16'd0 : 16'd2);
    tick(ADD_T1, ADD_T1, DS ? 16'd0 : 16'd2);
  endtask

  task automatic test_branch;
    do_reset();
    rs_data = 32'd5; rt_data = 32'd5;
    tick(BEQ, BEQ, 16'd0);
    tests++;
    if (bus_a.isBr !== 1'b1 || bus_a.imm !== 16'h0004) begin
      fails++; $display("FAIL beq_taken isBr=%b imm=%h exp 1/0004", bus_a.isBr, bus_a.imm);
    end
    rt_data = 32'd6; #1;
    tests++;
    if (bus_a.isBr !== 1'b0) begin
      fails++; $display("FAIL beq_not_taken isBr=%b exp 0", bus_a.isBr);
    end
    tick(ADD_T1, ADD_T1, 16'd0);
    tick(BNE, BNE, 16'd0);
    tests++;
    if (bus_a.isBr !== 1'b1) begin
      fails++; $display("FAIL bne_taken isBr=%b exp 1", bus_a.isBr);
    end
    rt_data = 32'd5; #1;
    tests++;
    if (bus_a.isBr !== 1'b0) begin
      fails++; $display("FAIL bne_not_taken isBr=%b exp 0", bus_a.isBr);
    end
    tick(ADD_T1, ADD_T1, 16'd0);
    tick(BEQ, BEQ, 16'd0);
    tick(ADD_T1, DS ? ADD_T1 : 32'd0, DS ? 16'd0 : 16'd1);
  endtask

  task automatic test_load_use;
    do_reset();
    tick(LW_T0, LW_T0, 16'd0);
    instr = ADD_T1; #1;
    tests++;
    if (bus_a.isBubble !== 1'b1) begin
      fails++; $display("FAIL lu_bubble got %b exp 1", bus_a.isBubble);
    end
    tick(ADD_T1, 32'd0, 16'd1);
    tests++;
    if (bus_a.isBubble !== 1'b0) begin
      fails++; $display("FAIL lu_one_cycle got %b exp 0", bus_a.isBubble);
    end
    tick(ADD_T1, ADD_T1, 16'd1);
    tick(LW_Z, LW_Z, 16'd1);
    instr = ADD_Z; #1;
    tests++;
    if (bus_a.isBubble !== 1'b0) begin
      fails++; $display("FAIL lu_zero_reg got %b exp 0", bus_a.isBubble);
    end
    tick(ADD_Z, ADD_Z, 16'd1);
  endtask

  task automatic test_back_to_back;
    do_reset();
    tick(LW_T0, LW_T0, 16'd0);
    tick(LW_T1, 32'd0, 16'd1);
    tick(LW_T1, LW_T1, 16'd1);
    tick(ADD_T2, 32'd0, 16'd2);
    tick(ADD_T2, ADD_T2, 16'd2);
  endtask

  task automatic test_jr_flush;
    do_reset();
    rs_data = 32'h00001000; rt_data = 32'd0;
    tick(JR, JR, 16'd0);
    tests++;
    if (bus_a.isJr !== 1'b1 || bus_a.rrs !== 32'h00001000 || bus_a.isBubble !== 1'b0) begin
      fails++; $display("FAIL jr_decode isJr=%b rrs=%h bub=%b exp 1/00001000/0",
                        bus_a.isJr, bus_a.rrs, bus_a.isBubble);
    end
    tick(ADD_T1, DS ? ADD_T1 : 32'd0, DS ? 16'd0 : 16'd1);
    tests++;
    if (bus_b.cmd !== (DS ? ADD_T1 : 32'd0)) begin
      fails++; $display("FAIL flush3_c1 got %h exp %h", bus_b.cmd, DS ? ADD_T1 : 32'd0);
    end
    tick(TGT, TGT, DS ? 16'd0 : 16'd1);
    tests++;
    if (bus_b.cmd !== (DS ? TGT : 32'd0)) begin
      fails++; $display("FAIL flush3_c2 got %h exp %h", bus_b.cmd, DS ? TGT : 32'd0);
    end
    tick(TGT, TGT, DS ? 16'd0 : 16'd1);
    tests++;
    if (bus_b.cmd !== (DS ? TGT : 32'd0)) begin
      fails++; $display("FAIL flush3_c3 got %h exp %h", bus_b.cmd, DS ? TGT : 32'd0);
    end
    tick(TGT, TGT, DS ? 16'd0 : 16'd1);
    tests++;
    if (bus_b.cmd !== TGT || bus_b.lostCnt !== (DS ? 16'd0 : 16'd3)) begin
      fails++; $display("FAIL flush3_done cmd=%h lost=%0d exp %h/%0d",
                        bus_b.cmd, bus_b.lostCnt, TGT, DS ? 0 : 3);
    end
    // Reset while dut_b is mid-FLUSH must drop it straight back to RUN.
    tick(JR, JR, DS ? 16'd0 : 16'd1);
    tick(ADD_T1, DS ? ADD_T1 : 32'd0, DS ? 16'd0 : 16'd2);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus_b.cmd !== 32'd0 || bus_b.lostCnt !== 16'd0) begin
      fails++; $display("FAIL flush_reset cmd=%h lost=%0d exp 0/0", bus_b.cmd, bus_b.lostCnt);
    end
    #2 rst_n = 1'b1;
    tick(TGT, TGT, 16'd0);
    tests++;
    if (bus_b.cmd !== TGT) begin
      fails++; $display("FAIL flush_reset_run got %h exp %h", bus_b.cmd, TGT);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick(LW_T0, LW_T0, 16'(k - 1));
      tick(ADD_T1, 32'd0, 16'(k));
      if (k == 14) begin
        tests++;
        if (bus_c.lostCnt !== 4'd14) begin
          fails++; $display("FAIL sat_pre got %0d exp 14", bus_c.lostCnt);
        end
      end
    end
    tests++;
    if (bus_c.lostCnt !== 4'd15) begin
      fails++; $display("FAIL sat_hold got %0d exp 15", bus_c.lostCnt);
    end
  endtask

  initial begin
    LW_T0  = i_type(6'h23, 5'd29, 5'd8, 16'h0000);
    LW_T1  = i_type(6'h23, 5'd8, 5'd9, 16'h0004);
    LW_Z   = i_type(6'h23, 5'd29, 5'd0, 16'h0008);
    ADD_T1 = r_type(5'd8, 5'd10, 5'd9, 6'h20);
    ADD_Z  = r_type(5'd0, 5'd0, 5'd9, 6'h20);
    ADD_T2 = r_type(5'd9, 5'd11, 5'd10, 6'h20);
    JMP    = {6'h02, 26'h0000040};
    JAL    = {6'h03, 26'h3FFFFFF};
    BEQ    = i_type(6'h04, 5'd1, 5'd2, 16'h0004);
    BNE    = i_type(6'h05, 5'd1, 5'd2, 16'h0008);
    JR     = r_type(5'd31, 5'd0, 5'd0, 6'h08);
    TGT    = r_type(5'd12, 5'd13, 5'd14, 6'h25);

    test_reset();
    test_jump();
    test_branch();
    test_load_use();
    test_back_to_back();
    test_jr_flush();
    test_saturation();

    @(posedge clk); #3;
    tests++;
    if (q_cmd.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d entries exp 0", q_cmd.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
